// File: rtl/flash_page_writer_if.sv
// Command bus between the CPU-side controller and the SPI flash page writer.
// The master issues one program/erase request at a time; the slave reports status.
interface flash_page_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_erase;
    logic [23:0] cmd_address;
    logic [31:0] cmd_data;
    logic        done;
    logic        error;
    logic        busy;

    modport master (
        output cmd_valid, cmd_erase, cmd_address, cmd_data,
        input  cmd_ready, done, error, busy
    );

    modport slave (
        input  cmd_valid, cmd_erase, cmd_address, cmd_data,
        output cmd_ready, done, error, busy
    );
endinterface

// File: rtl/flash_page_writer.sv
// SPI flash write engine: WREN, then page-program (one word) or sector erase,
// then RDSR polling until WIP clears. SPI mode 0, MSB first.
module flash_page_writer #(
    parameter int unsigned HALF_PERIOD  = 2,
    parameter int unsigned CS_GAP       = 4,
    parameter logic [23:0] PROTECT_BASE = 24'h100000,
    parameter logic [23:0] POLL_LIMIT   = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    flash_page_writer_if.slave   cmd,
    output logic                 flash_sck,
    output logic                 flash_csn,
    output logic                 flash_mosi,
    input  logic                 flash_miso
);

    localparam int unsigned HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP1, S_CMD, S_GAP2, S_POLL, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic                csn_q, csn_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          rx_q, rx_d;
    logic                last_q, last_d;
    logic                timeout_q, timeout_d;
    logic                reject_q, reject_d;
    logic [23:0]         poll_cnt_q, poll_cnt_d;
    logic                erase_q, erase_d;
    logic [23:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;

    logic [2:0]          byte_nxt;
    logic [7:0]          cmd_byte_nxt;
    logic                hp_end;
    logic                cmd_last_byte;

    assign byte_nxt      = byte_cnt_q + 3'd1;
    assign hp_end        = (hp_cnt_q == HP_LAST);
    assign cmd_last_byte = (byte_cnt_q == (erase_q ? 3'd3 : 3'd7));

    // Byte order on the wire: opcode, address high..low, then data little-endian.
    always_comb begin
        cmd_byte_nxt = 8'h00;
        unique case (byte_nxt)
            3'd0: cmd_byte_nxt = erase_q ? 8'h20 : 8'h02;
            3'd1: cmd_byte_nxt = addr_q[23:16];
            3'd2: cmd_byte_nxt = addr_q[15:8];
            3'd3: cmd_byte_nxt = addr_q[7:0];
            3'd4: cmd_byte_nxt = data_q[7:0];
            3'd5: cmd_byte_nxt = data_q[15:8];
            3'd6: cmd_byte_nxt = data_q[23:16];
            3'd7: cmd_byte_nxt = data_q[31:24];
        endcase
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d    = state_q;
        csn_d      = csn_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        hp_cnt_d   = hp_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        last_d     = last_q;
        timeout_d  = timeout_q;
        reject_d   = 1'b0;
        poll_cnt_d = poll_cnt_q;
        erase_d    = erase_q;
        addr_d     = addr_q;
        data_d     = data_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_address < PROTECT_BASE ||
                        (!cmd.cmd_erase && cmd.cmd_address[1:0] != 2'b00)) begin
                        reject_d = 1'b1;
                    end else begin
                        erase_d    = cmd.cmd_erase;
                        addr_d     = cmd.cmd_address;
                        data_d     = cmd.cmd_data;
                        state_d    = S_WREN;
                        csn_d      = 1'b0;
                        sck_d      = 1'b0;
                        tx_d       = 8'h06;
                        mosi_d     = 1'b0;
                        hp_cnt_d   = '0;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        last_d     = 1'b0;
                        timeout_d  = 1'b0;
                        poll_cnt_d = '0;
                    end
                end
            end

            S_GAP1, S_GAP2: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = (state_q == S_GAP1) ? S_CMD : S_POLL;
                    tx_d       = (state_q == S_GAP2) ? 8'h05 : (erase_q ? 8'h20 : 8'h02);
                    mosi_d     = 1'b0;
                    csn_d      = 1'b0;
                    sck_d      = 1'b0;
                    hp_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    last_d     = 1'b0;
                end
            end

            S_FINISH: state_d = S_IDLE;

            default: begin
                // Shared shifter for WREN / CMD / POLL; one transfer per CS assertion.
                hp_cnt_d = hp_end ? '0 : hp_cnt_q + 1'b1;
                if (hp_end && !sck_q) begin
                    if (last_q) begin
                        csn_d     = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (state_q == S_WREN) ? S_GAP1 :
                                    (state_q == S_CMD)  ? S_GAP2 : S_FINISH;
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], flash_miso};
                    end
                end else if (hp_end) begin
                    sck_d     = 1'b0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q != 3'd7) begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end else begin
                        byte_cnt_d = byte_nxt;
                        mosi_d     = 1'b0;
                        tx_d       = 8'h00;
                        if (state_q == S_WREN) begin
                            last_d = 1'b1;
                        end else if (state_q == S_CMD) begin
                            if (cmd_last_byte) begin
                                last_d = 1'b1;
                            end else begin
                                tx_d   = cmd_byte_nxt;
                                mosi_d = cmd_byte_nxt[7];
                            end
                        end else begin
                            byte_cnt_d = 3'd1;
                            // rx_q now holds a whole status byte; bit0 is WIP.
                            if (byte_cnt_q != 3'd0) begin
                                if (!rx_q[0]) begin
                                    last_d = 1'b1;
                                end else if (poll_cnt_q == POLL_LIMIT - 24'd1) begin
                                    last_d    = 1'b1;
                                    timeout_d = 1'b1;
                                end else begin
                                    poll_cnt_d = poll_cnt_q + 24'd1;
                                end
                            end
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            csn_q      <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            hp_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            last_q     <= 1'b0;
            timeout_q  <= 1'b0;
            reject_q   <= 1'b0;
            poll_cnt_q <= '0;
            erase_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            csn_q      <= csn_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            hp_cnt_q   <= hp_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            last_q     <= last_d;
            timeout_q  <= timeout_d;
            reject_q   <= reject_d;
            poll_cnt_q <= poll_cnt_d;
            erase_q    <= erase_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign cmd.busy      = (state_q != S_IDLE);
    assign cmd.done      = (state_q == S_FINISH) && !timeout_q;
    assign cmd.error     = reject_q || ((state_q == S_FINISH) && timeout_q);
    assign flash_sck     = sck_q;
    assign flash_csn     = csn_q;
    assign flash_mosi    = mosi_q;

endmodule

// File: tb/tb_flash_page_writer.sv
// Directed bench for flash_page_writer: a small SPI flash model logs MOSI bytes
// per CS group and returns scripted status bytes on MISO.
module tb_flash_page_writer;

    localparam int CS_GAP = 4;

    logic clk;
    logic reset;
    logic flash_sck, flash_csn, flash_mosi;
    logic flash_miso = 1'b0;
    logic l_sck, l_csn, l_mosi;
    logic l_miso;

    flash_page_writer_if ifc ();
    flash_page_writer_if lim_if ();

    flash_page_writer #(.HALF_PERIOD(2), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset(reset), .cmd(ifc),
        .flash_sck(flash_sck), .flash_csn(flash_csn),
        .flash_mosi(flash_mosi), .flash_miso(flash_miso)
    );

    flash_page_writer #(.HALF_PERIOD(2), .CS_GAP(CS_GAP), .POLL_LIMIT(24'd3)) dut_lim (
        .clk(clk), .reset(reset), .cmd(lim_if),
        .flash_sck(l_sck), .flash_csn(l_csn),
        .flash_mosi(l_mosi), .flash_miso(l_miso)
    );

    assign l_miso = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- flash model / monitor (written only here) ----------------
    logic [7:0] status_seq[$];
    logic [7:0] log_bytes[$];
    int         grp_len[$];
    int         gaps[$];
    int rbit = 0, nbits = 0, cur_len = 0, gap_run = 0;
    logic [7:0] sh = 8'h00;
    logic sck_p = 1'b0, csn_p = 1'b1, seen_low = 1'b0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, low_cnt = 0, idle_sck_viol = 0;
    logic lsck_p = 1'b0, lcsn_p = 1'b1;
    logic [7:0] lim_sh = 8'h00, lim_first = 8'h00;
    int lim_rises = 0, lim_groups = 0, lim_done = 0, lim_err = 0;

    function automatic logic status_bit(input int r);
        logic [7:0] b;
        int k;
        if (r < 8 || status_seq.size() == 0) return 1'b0;
        k = (r - 8) / 8;
        b = (k < status_seq.size()) ? status_seq[k] : status_seq[status_seq.size()-1];
        return b[7 - ((r - 8) % 8)];
    endfunction

    always @(negedge clk) begin
        if (flash_csn === 1'b0 && csn_p) begin
            rbit = 0; nbits = 0; cur_len = 0; flash_miso = 1'b0;
        end
        if (flash_csn === 1'b1 && !csn_p) grp_len.push_back(cur_len);
        if (flash_csn === 1'b0 && flash_sck && !sck_p) begin
            sh = {sh[6:0], flash_mosi};
            nbits++; rbit++;
            if (nbits == 8) begin
                log_bytes.push_back(sh); cur_len++; nbits = 0;
            end
        end
        if (flash_csn === 1'b0 && !flash_sck && sck_p) flash_miso = status_bit(rbit);
        if (ifc.busy !== 1'b1) begin
            seen_low = 1'b0; gap_run = 0;
        end else if (flash_csn === 1'b0) begin
            if (seen_low && gap_run > 0) gaps.push_back(gap_run);
            seen_low = 1'b1; gap_run = 0;
        end else if (seen_low) begin
            gap_run++;
        end
        if (ifc.done === 1'b1) done_cnt++;
        if (ifc.error === 1'b1) err_cnt++;
        if (ifc.done === 1'b1 && ifc.error === 1'b1) both_cnt++;
        if (flash_csn === 1'b0) low_cnt++;
        if (flash_csn === 1'b1 && flash_sck === 1'b1) idle_sck_viol++;
        if (l_csn === 1'b1 && l_sck === 1'b1) idle_sck_viol++;
        if (l_csn === 1'b0 && lcsn_p) lim_groups++;
        if (l_csn === 1'b0 && l_sck && !lsck_p) begin
            lim_sh = {lim_sh[6:0], l_mosi};
            lim_rises++;
            if (lim_rises == 8) lim_first = lim_sh;
        end
        if (lim_if.done === 1'b1) lim_done++;
        if (lim_if.error === 1'b1) lim_err++;
        sck_p = flash_sck; csn_p = flash_csn;
        lsck_p = l_sck; lcsn_p = l_csn;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] exp_bytes[$];
    int         exp_grp[$];

    task automatic verify_log(input string pfx, input int b0, input int g0);
        check({pfx, "_n_groups"}, grp_len.size() - g0, exp_grp.size());
        for (int i = 0; i < exp_grp.size(); i++)
            if (g0 + i < grp_len.size())
                check($sformatf("%s_grp%0d_len", pfx, i), grp_len[g0+i], exp_grp[i]);
        check({pfx, "_n_bytes"}, log_bytes.size() - b0, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            if (b0 + i < log_bytes.size())
                check($sformatf("%s_byte%0d", pfx, i), log_bytes[b0+i], exp_bytes[i]);
    endtask

    task automatic wait_end(input string pfx, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.done || ifc.error) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({pfx, "_wait_timeout"}, 0, 1);
    endtask

    // Issue a valid command, optionally hold cmd_valid with a different request
    // until completion, then compare the logged wire traffic to exp_bytes/exp_grp.
    task automatic run_txn(input string pfx, input logic er, input logic [23:0] a,
                           input logic [31:0] d, input bit hold);
        int b0, g0, gp0, d0, e0, mn;
        b0 = log_bytes.size(); g0 = grp_len.size(); gp0 = gaps.size();
        d0 = done_cnt; e0 = err_cnt;
        ifc.cmd_valid = 1'b1; ifc.cmd_erase = er; ifc.cmd_address = a; ifc.cmd_data = d;
        @(negedge clk);
        check({pfx, "_csn_fall"}, flash_csn, 1'b0);
        check({pfx, "_busy"}, ifc.busy, 1'b1);
        check({pfx, "_ready_low"}, ifc.cmd_ready, 1'b0);
        if (hold) begin
            ifc.cmd_address = 24'h200000; ifc.cmd_data = 32'hDEADBEEF;
        end else begin
            ifc.cmd_valid = 1'b0;
        end
        wait_end(pfx, 3000);
        ifc.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check({pfx, "_ready_back"}, ifc.cmd_ready, 1'b1);
        check({pfx, "_busy_clear"}, ifc.busy, 1'b0);
        check({pfx, "_done_once"}, done_cnt - d0, 1);
        check({pfx, "_no_error"}, err_cnt - e0, 0);
        check({pfx, "_n_gaps"}, gaps.size() - gp0, 2);
        mn = 1000;
        for (int i = gp0; i < gaps.size(); i++) if (gaps[i] < mn) mn = gaps[i];
        check({pfx, "_cs_gap"}, (mn >= CS_GAP), 1'b1);
        verify_log(pfx, b0, g0);
    endtask

    task automatic reject_case(input string pfx, input logic [23:0] a);
        int l0, d0, e0;
        l0 = low_cnt; d0 = done_cnt; e0 = err_cnt;
        ifc.cmd_valid = 1'b1; ifc.cmd_erase = 1'b0; ifc.cmd_address = a; ifc.cmd_data = 32'h0;
        @(negedge clk);
        check({pfx, "_error"}, ifc.error, 1'b1);
        check({pfx, "_ready"}, ifc.cmd_ready, 1'b1);
        check({pfx, "_busy"}, ifc.busy, 1'b0);
        ifc.cmd_valid = 1'b0;
        @(negedge clk);
        check({pfx, "_error_pulse"}, ifc.error, 1'b0);
        repeat (8) @(negedge clk);
        check({pfx, "_no_csn"}, low_cnt - l0, 0);
        check({pfx, "_no_done"}, done_cnt - d0, 0);
        check({pfx, "_err_once"}, err_cnt - e0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b0, d0, e0;
        bit seen;
        reset = 1'b1;
        ifc.cmd_valid = 1'b0; ifc.cmd_erase = 1'b0; ifc.cmd_address = '0; ifc.cmd_data = '0;
        lim_if.cmd_valid = 1'b0; lim_if.cmd_erase = 1'b0;
        lim_if.cmd_address = '0; lim_if.cmd_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ifc.cmd_ready, 1'b1);
        check("rst_busy",  ifc.busy, 1'b0);
        check("rst_done",  ifc.done, 1'b0);
        check("rst_error", ifc.error, 1'b0);
        check("rst_csn",   flash_csn, 1'b1);
        check("rst_sck",   flash_sck, 1'b0);
        check("rst_mosi",  flash_mosi, 1'b0);

        // Program with cmd_valid held high (different address) during the operation.
        status_seq = '{8'h01, 8'h01, 8'h00};
        exp_bytes  = '{8'h06, 8'h02, 8'h10, 8'h00, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12,
                       8'h05, 8'h00, 8'h00, 8'h00};
        exp_grp    = '{1, 8, 4};
        run_txn("pp", 1'b0, 24'h100004, 32'h12345678, 1'b1);

        status_seq = '{8'h01, 8'h00};
        exp_bytes  = '{8'h06, 8'h20, 8'h12, 8'h34, 8'h56, 8'h05, 8'h00, 8'h00};
        exp_grp    = '{1, 4, 3};
        run_txn("se", 1'b1, 24'h123456, 32'hFFFFFFFF, 1'b0);

        reject_case("prot", 24'h0FFFFC);
        reject_case("misal", 24'h100002);

        // Reset during the second address byte of PP.
        status_seq = '{8'h00};
        b0 = log_bytes.size();
        ifc.cmd_valid = 1'b1; ifc.cmd_erase = 1'b0;
        ifc.cmd_address = 24'h100008; ifc.cmd_data = 32'hA5A5A5A5;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (log_bytes.size() - b0 >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("mrst_wait_timeout", 0, 1);
        repeat (10) @(negedge clk);
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_csn",   flash_csn, 1'b1);
        check("mrst_sck",   flash_sck, 1'b0);
        check("mrst_ready", ifc.cmd_ready, 1'b1);
        check("mrst_busy",  ifc.busy, 1'b0);
        repeat (6) @(negedge clk);
        check("mrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        exp_bytes = '{8'h06, 8'h02, 8'h10, 8'h00, 8'h10, 8'h0D, 8'hF0, 8'hFE, 8'hCA,
                      8'h05, 8'h00};
        exp_grp   = '{1, 8, 2};
        run_txn("post", 1'b0, 24'h100010, 32'hCAFEF00D, 1'b0);

        // Poll timeout on the POLL_LIMIT=3 instance, MISO stuck high.
        lim_if.cmd_valid = 1'b1; lim_if.cmd_erase = 1'b0;
        lim_if.cmd_address = 24'h100000; lim_if.cmd_data = 32'h0;
        @(negedge clk);
        lim_if.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (lim_if.done || lim_if.error) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("lim_wait_timeout", 0, 1);
        repeat (4) @(negedge clk);
        check("lim_rises",  lim_rises, 8 + 64 + 8 + 3 * 8);
        check("lim_groups", lim_groups, 3);
        check("lim_first",  lim_first, 8'h06);
        check("lim_error",  lim_err, 1);
        check("lim_done",   lim_done, 0);
        check("lim_ready",  lim_if.cmd_ready, 1'b1);

        check("done_error_overlap", both_cnt, 0);
        check("sck_while_cs_high",  idle_sck_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
